// File: rtl/trace_packetizer.sv
// Packs retired-instruction trace words into multi-slot packets on a valid/ready port.
// The input is never stalled: words that find the FIFO full are dropped and counted.
module trace_packetizer #(
  parameter int DEPTH        = 16,
  parameter int ENTRIES      = 4,
  parameter int FLUSH_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    trace_valid,
  input  logic [35:0]             trace_data,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [36*ENTRIES-1:0]   out_data,
  output logic [3:0]              out_count,
  output logic [15:0]             out_seq,
  output logic [15:0]             drop_count,
  output logic                    overflow,
  output logic                    flush_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);
  localparam logic [3:0]    ENTRIES_W = 4'(ENTRIES);
  localparam logic [TW-1:0] TIMER_MAX = TW'(FLUSH_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_SEND} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [35:0]   r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [35:0]   r_slots [ENTRIES];
  logic [3:0]    r_cnt;
  logic [TW-1:0] r_timer;
  logic [15:0]   r_seq;
  logic [15:0]   r_drop;
  logic          r_overflow;
  logic          r_flush_pending;
  logic          r_flush_done;

  logic [AW:0]   w_occ;
  logic          w_empty;
  logic          w_full;
  logic [35:0]   w_rd_data;
  logic          w_pop;
  logic          w_handshake;
  logic          w_timer_inc;
  logic          w_wr_en;
  logic          w_drop;
  logic          w_flush_req;
  logic          w_flush_fire;

  assign w_occ     = r_wr_ptr - r_rd_ptr;
  assign w_empty   = (w_occ == '0);
  assign w_full    = (w_occ == DEPTH_W);
  assign w_rd_data = r_mem[r_rd_ptr[AW-1:0]];

  // A pop at the same edge frees a slot, so a write into a full FIFO still lands.
  assign w_wr_en = trace_valid && (!w_full || w_pop);
  assign w_drop  = trace_valid && !w_wr_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_handshake  = 1'b0;
    w_timer_inc  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = (ENTRIES == 1) ? S_SEND : S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (r_cnt + 4'd1 == ENTRIES_W) w_state_next = S_SEND;
        end else begin
          w_timer_inc = 1'b1;
          if ((r_timer + TW'(1) == TIMER_MAX) || r_flush_pending) w_state_next = S_SEND;
        end
      end
      S_SEND: begin
        if (out_ready) begin
          w_handshake = 1'b1;
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_state_next = (ENTRIES == 1) ? S_SEND : S_COLLECT;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= trace_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_drop     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) r_slots[i] <= '0;
      r_cnt   <= '0;
      r_timer <= '0;
      r_seq   <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (w_handshake)                     r_slots[i] <= (w_pop && i == 0) ? w_rd_data : '0;
        else if (w_pop && r_cnt == 4'(i))    r_slots[i] <= w_rd_data;
      end
      if (w_handshake) begin
        r_cnt <= w_pop ? 4'd1 : 4'd0;
        r_seq <= r_seq + 16'd1;
      end else if (w_pop) begin
        r_cnt <= r_cnt + 4'd1;
      end
      if (w_pop || w_handshake) r_timer <= '0;
      else if (w_timer_inc)     r_timer <= r_timer + TW'(1);
    end
  end

  // The drain is complete once nothing is queued, in flight or arriving: either idle
  // with an empty FIFO, or the handshake that empties the packer.
  assign w_flush_req  = flush || r_flush_pending;
  assign w_flush_fire = w_flush_req && w_empty && !trace_valid &&
                        ((r_state == S_IDLE) || w_handshake);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flush_pending <= 1'b0;
      r_flush_done    <= 1'b0;
    end else begin
      r_flush_done    <= w_flush_fire;
      r_flush_pending <= w_flush_req && !w_flush_fire;
    end
  end

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_slot
    assign out_data[36*gi +: 36] = r_slots[gi];
  end

  assign out_valid  = (r_state == S_SEND);
  assign out_count  = r_cnt;
  assign out_seq    = r_seq;
  assign drop_count = r_drop;
  assign overflow   = r_overflow;
  assign flush_done = r_flush_done;

endmodule
